aes128_encrypt_iter: RTL

- Iterative AES-128 forward cipher: SubBytes, ShiftRows, MixColumns and AddRoundKey, one round per clock, with round keys expanded on the fly.
- Encrypt-direction counterpart to the existing INV_SHIFT_ROWS / inverse-round decrypt path. It produces the ciphertext that the decrypt path consumes.
- Valid/ready handshakes on input and output. One block in flight at a time.

---
 rtl/aes_pkg.sv | 75 +++++++
 rtl/aes_sbox.sv | 41 ++++
 rtl/aes128_encrypt_iter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 encrypt datapath.
//   - AES-128 round count and FSM state enum
//   - byte indexing helpers (byte 0 = bits [127:120], column-major)
//   - round-constant table
//   - GF(2^8) xtime / multiply and single-column MixColumns
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aesState_e;

  // Byte i of a 128-bit block; byte 0 is the most significant.
  function automatic logic [7:0] getByte(input logic [127:0] blk, input int idx);
    return blk[127 - 8*idx -: 8];
  endfunction

  // State is column-major: (row, col) lives at byte row + 4*col.
  function automatic int byteIdx(input int row, input int col);
    return row + 4*col;
  endfunction

  // Round constant for rounds 1..10; other indices are never used.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // One MixColumns column; col[31:24] is row 0.
  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
// Computed arithmetically (multiplicative inverse in GF(2^8) followed by the
// affine transform) instead of a 256-entry table; the inverse of 0 maps to 0.
// Ports:
//   i_byte  in  8  input byte
//   o_byte  out 8  substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_inv;

  // b^254 == b^-1, built with an addition chain of squarings and multiplies.
  always_comb begin
    logic [7:0] p2, p3, p6, p7, p14, p15, p30, p31, p62, p63, p126, p127;
    p2   = gfMul(i_byte, i_byte);
    p3   = gfMul(p2, i_byte);
    p6   = gfMul(p3, p3);
    p7   = gfMul(p6, i_byte);
    p14  = gfMul(p7, p7);
    p15  = gfMul(p14, i_byte);
    p30  = gfMul(p15, p15);
    p31  = gfMul(p30, i_byte);
    p62  = gfMul(p31, p31);
    p63  = gfMul(p62, i_byte);
    p126 = gfMul(p63, p63);
    p127 = gfMul(p126, i_byte);
    w_inv = gfMul(p127, p127);
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one full round per clock, round keys expanded
// on the fly. One block in flight; valid/ready on both sides.
// Ports:
//   clk         in   1    rising-edge clock
//   rst         in   1    synchronous active-high reset
//   in_valid    in   1    plaintext/key offered
//   in_ready    out  1    high in IDLE
//   plaintext   in   128  byte 0 = [127:120], column-major
//   key         in   128  cipher key, same byte order
//   out_valid   out  1    ciphertext valid, held until accepted
//   out_ready   in   1    downstream accepts ciphertext
//   ciphertext  out  128  result, same byte order
//   busy        out  1    high in RUN or DONE
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  if (NR != NR_AES128) begin : gNrCheck
    $error("aes128_encrypt_iter: NR must be 10 for AES-128");
  end

  aesState_e    r_fsm;
  aesState_e    w_fsmNext;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [127:0] r_ciphertext;

  logic [7:0]   w_subBytes [16];
  logic [7:0]   w_shifted  [16];
  logic [127:0] w_srPacked;
  logic [127:0] w_mixed;
  logic [31:0]  w_rotWord;
  logic [31:0]  w_subWord;
  logic [127:0] w_rkNext;

  // SubBytes on all 16 state bytes, then ShiftRows: row r rotates left by r,
  // so output (r,c) takes input (r,(c+r) mod 4).
  for (genvar i = 0; i < 16; i++) begin : gStateSbox
    aes_sbox uSbox (
      .i_byte(getByte(r_state, i)),
      .o_byte(w_subBytes[i])
    );
  end

  for (genvar r = 0; r < 4; r++) begin : gShiftRow
    for (genvar c = 0; c < 4; c++) begin : gShiftCol
      assign w_shifted[byteIdx(r, c)] = w_subBytes[byteIdx(r, (c + r) % 4)];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : gPack
    assign w_srPacked[127 - 8*i -: 8] = w_shifted[i];
  end

  for (genvar c = 0; c < 4; c++) begin : gMix
    assign w_mixed[127 - 32*c -: 32] = mixColumn(w_srPacked[127 - 32*c -: 32]);
  end

  // Key schedule step: SubWord(RotWord(w3)) feeds w0', then the XOR ripple.
  assign w_rotWord = {r_rk[23:0], r_rk[31:24]};

  for (genvar i = 0; i < 4; i++) begin : gKeySbox
    aes_sbox uSbox (
      .i_byte(w_rotWord[31 - 8*i -: 8]),
      .o_byte(w_subWord[31 - 8*i -: 8])
    );
  end

  always_comb begin
    logic [31:0] w0, w1, w2, w3;
    w0 = r_rk[127:96] ^ w_subWord ^ {rcon(r_round), 24'h000000};
    w1 = r_rk[95:64] ^ w0;
    w2 = r_rk[63:32] ^ w1;
    w3 = r_rk[31:0]  ^ w2;
    w_rkNext = {w0, w1, w2, w3};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsmNext;
  end

  // FSM next-state logic.
  always_comb begin
    w_fsmNext = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid) w_fsmNext = RUN;
      RUN:     if (r_round == 4'(NR)) w_fsmNext = DONE;
      DONE:    if (out_ready) w_fsmNext = IDLE;
      default: w_fsmNext = IDLE;
    endcase
  end

  // FSM outputs; out_valid is exactly "in DONE", which holds it until taken.
  always_comb begin
    in_ready  = (r_fsm == IDLE);
    out_valid = (r_fsm == DONE);
    busy      = (r_fsm == RUN) || (r_fsm == DONE);
  end

  // Datapath registers. The round counter stops at NR in the last round and
  // returns to 0 when the output handshake sends the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= '0;
      r_rk         <= '0;
      r_ciphertext <= '0;
      r_round      <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= plaintext ^ key;
            r_rk    <= key;
            r_round <= 4'd1;
          end
        end
        RUN: begin
          r_rk <= w_rkNext;
          if (r_round == 4'(NR)) begin
            r_ciphertext <= w_srPacked ^ w_rkNext;
          end else begin
            r_state <= w_mixed ^ w_rkNext;
            r_round <= r_round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) r_round <= '0;
        end
        default: r_round <= '0;
      endcase
    end
  end

  assign ciphertext = r_ciphertext;

endmodule
